// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
//
// Shared definitions for the button input path (debouncer + event decoder).
//
// Contents:
//   btn_state_e        - 2-bit state encoding of the event decoder FSM
//                        (IDLE=0, PRESS=1, HOLD=2, GAP=3).
//   CLK_FREQ_HZ        - system clock frequency the defaults are sized for.
//   DEBOUNCE_COUNT     - debouncer settle time (10 ms at 100 MHz).
//   LONG_COUNT_DEF     - hold time before a long press (500 ms).
//   REPEAT_COUNT_DEF   - auto-repeat period while held long (100 ms).
//   DOUBLE_WINDOW_DEF  - double-click window after a short release (250 ms).
//   max3()             - helper used to size the shared event counter.
// -----------------------------------------------------------------------------
package button_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_HOLD  = 2'd2,
    ST_GAP   = 2'd3
  } btn_state_e;

  localparam int unsigned CLK_FREQ_HZ       = 100_000_000;
  localparam int unsigned DEBOUNCE_COUNT    = 1_000_000;
  localparam int unsigned LONG_COUNT_DEF    = 50_000_000;
  localparam int unsigned REPEAT_COUNT_DEF  = 10_000_000;
  localparam int unsigned DOUBLE_WINDOW_DEF = 25_000_000;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/button_event_decoder.sv
// -----------------------------------------------------------------------------
// button_event_decoder
//
// Turns the debounced, synchronous button level into one-cycle event pulses
// for the control logic: press, release, short press, long press, auto-repeat
// and double-click, plus a "held" level.
//
// Parameters (all must be >= 2):
//   LONG_COUNT     - cycles of continuous hold before long_press.
//   REPEAT_COUNT   - cycles between repeat_pulse while in long hold.
//   DOUBLE_WINDOW  - cycles after a short release in which a new press is a
//                    double-click.
//
// Ports:
//   clk_in        in   system clock
//   reset         in   asynchronous, active-high reset
//   btn_in        in   debounced button level, 1 = pressed
//   press_pulse   out  one cycle on each press
//   release_pulse out  one cycle on each release
//   short_press   out  one cycle on release of a press shorter than LONG_COUNT
//   long_press    out  one cycle when a hold reaches LONG_COUNT
//   repeat_pulse  out  one cycle every REPEAT_COUNT while in long hold
//   double_click  out  one cycle on a qualifying second press
//   held          out  level, 1 while in PRESS or HOLD
//   state_dbg_o   out  current FSM state (btn_state_e encoding), debug only
//
// Interface semantics: there is no valid/ready handshake. Every event output
// is a fire-and-forget single-cycle pulse; consumers must sample every cycle
// and no event is ever held back or replayed.
//
// All outputs are registered and decoded from the next state, so an event is
// visible for exactly the cycle after the edge that sampled its cause.
// -----------------------------------------------------------------------------
module button_event_decoder
  import button_pkg::*;
#(
  parameter int unsigned LONG_COUNT    = LONG_COUNT_DEF,
  parameter int unsigned REPEAT_COUNT  = REPEAT_COUNT_DEF,
  parameter int unsigned DOUBLE_WINDOW = DOUBLE_WINDOW_DEF
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       btn_in,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       short_press,
  output logic       long_press,
  output logic       repeat_pulse,
  output logic       double_click,
  output logic       held,
  output logic [1:0] state_dbg_o
);

  // One counter serves all three timed states. It is cleared on every state
  // entry and each state either leaves or clears at its terminal count, so the
  // largest value it ever holds is max(param) - 1.
  localparam int unsigned CNT_MAX = max3(LONG_COUNT, REPEAT_COUNT, DOUBLE_WINDOW);
  localparam int          CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_COUNT - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_COUNT - 1);
  localparam logic [CNT_W-1:0] WINDOW_LAST = CNT_W'(DOUBLE_WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dbl_seen_q, dbl_seen_d;

  logic press_q, press_d;
  logic release_q, release_d;
  logic short_q, short_d;
  logic long_q, long_d;
  logic repeat_q, repeat_d;
  logic dclick_q, dclick_d;
  logic held_q, held_d;

  // ---------------------------------------------------------------------------
  // Next-state and event decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_ONE;
    dbl_seen_d = dbl_seen_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    short_d    = 1'b0;
    long_d     = 1'b0;
    repeat_d   = 1'b0;
    dclick_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // The counter rests at zero while idle.
        cnt_d = CNT_ZERO;
        if (btn_in) begin
          state_d = ST_PRESS;
          press_d = 1'b1;
        end
      end

      ST_PRESS: begin
        // Release is checked first so a release on the threshold edge is
        // still a short press and never a long press.
        if (!btn_in) begin
          release_d = 1'b1;
          short_d   = 1'b1;
          cnt_d     = CNT_ZERO;
          // The release that ends a double-click goes straight to IDLE, so a
          // third press cannot chain into another double-click.
          state_d   = dbl_seen_q ? ST_IDLE : ST_GAP;
        end else if (cnt_q == LONG_LAST) begin
          state_d = ST_HOLD;
          long_d  = 1'b1;
          cnt_d   = CNT_ZERO;
        end
      end

      ST_HOLD: begin
        // Release pre-empts a repeat that would land on the same edge.
        if (!btn_in) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
          cnt_d     = CNT_ZERO;
        end else if (cnt_q == REPEAT_LAST) begin
          repeat_d = 1'b1;
          cnt_d    = CNT_ZERO;
        end
      end

      ST_GAP: begin
        // A press on the last window cycle still qualifies; the window only
        // expires when that cycle is sampled with the button released.
        if (btn_in) begin
          state_d    = ST_PRESS;
          press_d    = 1'b1;
          dclick_d   = 1'b1;
          dbl_seen_d = 1'b1;
          cnt_d      = CNT_ZERO;
        end else if (cnt_q == WINDOW_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    // Double-click memory lasts only until the gesture returns to IDLE.
    if (state_d == ST_IDLE) begin
      dbl_seen_d = 1'b0;
    end

    held_d = (state_d == ST_PRESS) || (state_d == ST_HOLD);
  end

  // ---------------------------------------------------------------------------
  // State, counter, flag and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= CNT_ZERO;
      dbl_seen_q <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
      repeat_q   <= 1'b0;
      dclick_q   <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dbl_seen_q <= dbl_seen_d;
      press_q    <= press_d;
      release_q  <= release_d;
      short_q    <= short_d;
      long_q     <= long_d;
      repeat_q   <= repeat_d;
      dclick_q   <= dclick_d;
      held_q     <= held_d;
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign short_press   = short_q;
  assign long_press    = long_q;
  assign repeat_pulse  = repeat_q;
  assign double_click  = dclick_q;
  assign held          = held_q;
  assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// -----------------------------------------------------------------------------
// tb_button_event_decoder
//
// Directed bench for button_event_decoder with LONG_COUNT=8, REPEAT_COUNT=4,
// DOUBLE_WINDOW=6. Each scenario task drives btn_in one cycle at a time and
// compares {state, event vector} one time unit after every rising edge against
// a hand-derived table.
//
// Event vector bit order (MSB..LSB):
//   press, release, short, long, repeat, double_click, held
// -----------------------------------------------------------------------------
module tb_button_event_decoder;

  localparam int unsigned T_LONG   = 8;
  localparam int unsigned T_REPEAT = 4;
  localparam int unsigned T_WINDOW = 6;

  localparam logic [6:0] Z  = 7'b0000000;
  localparam logic [6:0] P  = 7'b1000000;
  localparam logic [6:0] R  = 7'b0100000;
  localparam logic [6:0] S  = 7'b0010000;
  localparam logic [6:0] L  = 7'b0001000;
  localparam logic [6:0] RP = 7'b0000100;
  localparam logic [6:0] D  = 7'b0000010;
  localparam logic [6:0] H  = 7'b0000001;

  localparam logic [1:0] SI = 2'd0;
  localparam logic [1:0] SP = 2'd1;
  localparam logic [1:0] SH = 2'd2;
  localparam logic [1:0] SG = 2'd3;

  logic       clk_in;
  logic       reset;
  logic       btn_in;
  logic       press_pulse;
  logic       release_pulse;
  logic       short_press;
  logic       long_press;
  logic       repeat_pulse;
  logic       double_click;
  logic       held;
  logic [1:0] state_dbg_o;
  logic [8:0] got;

  int vectors;
  int errors;

  button_event_decoder #(
    .LONG_COUNT    (T_LONG),
    .REPEAT_COUNT  (T_REPEAT),
    .DOUBLE_WINDOW (T_WINDOW)
  ) dut (
    .clk_in        (clk_in),
    .reset         (reset),
    .btn_in        (btn_in),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .short_press   (short_press),
    .long_press    (long_press),
    .repeat_pulse  (repeat_pulse),
    .double_click  (double_click),
    .held          (held),
    .state_dbg_o   (state_dbg_o)
  );

  assign got = {state_dbg_o, press_pulse, release_pulse, short_press,
                long_press, repeat_pulse, double_click, held};

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // ---------------------------------------------------------------------------
  // Driver: present btn_in, let one rising edge sample it, settle 1 time unit.
  // ---------------------------------------------------------------------------
  task automatic drive_cycle(input logic b);
    btn_in = b;
    @(posedge clk_in);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset  = 1'b1;
    btn_in = 1'b0;
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    vectors++;
    if (got !== {SI, Z}) begin
      errors++;
      $display("FAIL reset_idle: got %b want %b", got, {SI, Z});
    end
    // A pressed button must not leak through while reset is held.
    drive_cycle(1'b1);
    vectors++;
    if (got !== {SI, Z}) begin
      errors++;
      $display("FAIL reset_btn_high: got %b want %b", got, {SI, Z});
    end
    btn_in = 1'b0;
    reset  = 1'b0;
    drive_cycle(1'b0);
    vectors++;
    if (got !== {SI, Z}) begin
      errors++;
      $display("FAIL reset_release_idle: got %b want %b", got, {SI, Z});
    end
  endtask

  task automatic test_short_press();
    logic       bv [10];
    logic [8:0] ev [10];
    bv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    ev = '{{SP, P | H}, {SP, H}, {SP, H}, {SG, R | S},
           {SG, Z}, {SG, Z}, {SG, Z}, {SG, Z}, {SG, Z}, {SI, Z}};
    for (int i = 0; i < 10; i++) begin
      drive_cycle(bv[i]);
      vectors++;
      if (got !== ev[i]) begin
        errors++;
        $display("FAIL short_press[%0d]: got %b want %b", i, got, ev[i]);
      end
    end
  endtask

  task automatic test_long_hold();
    logic       bv [22];
    logic [8:0] ev [22];
    for (int i = 0; i < 22; i++) bv[i] = (i < 20);
    ev = '{{SP, P | H}, {SP, H}, {SP, H}, {SP, H}, {SP, H}, {SP, H}, {SP, H},
           {SP, H}, {SH, L | H}, {SH, H}, {SH, H}, {SH, H}, {SH, RP | H},
           {SH, H}, {SH, H}, {SH, H}, {SH, RP | H}, {SH, H}, {SH, H}, {SH, H},
           {SI, R}, {SI, Z}};
    for (int i = 0; i < 22; i++) begin
      drive_cycle(bv[i]);
      vectors++;
      if (got !== ev[i]) begin
        errors++;
        $display("FAIL long_hold[%0d]: got %b want %b", i, got, ev[i]);
      end
    end
  endtask

  task automatic test_double_click();
    logic       bv [20];
    logic [8:0] ev [20];
    bv = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
           1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    ev = '{{SP, P | H}, {SP, H}, {SG, R | S}, {SG, Z}, {SG, Z},
           {SP, P | D | H}, {SP, H}, {SI, R | S}, {SI, Z}, {SI, Z},
           {SP, P | H}, {SP, H}, {SP, H}, {SG, R | S}, {SG, Z},
           {SG, Z}, {SG, Z}, {SG, Z}, {SG, Z}, {SI, Z}};
    for (int i = 0; i < 20; i++) begin
      drive_cycle(bv[i]);
      vectors++;
      if (got !== ev[i]) begin
        errors++;
        $display("FAIL double_click[%0d]: got %b want %b", i, got, ev[i]);
      end
    end
  endtask

  // Gap of 7 low cycles expires the window; a gap of exactly 6 still qualifies.
  task automatic test_window_edges();
    logic       bv [18];
    logic [8:0] ev [18];
    bv = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    ev = '{{SP, P | H}, {SG, R | S}, {SG, Z}, {SG, Z}, {SG, Z}, {SG, Z},
           {SG, Z}, {SI, Z}, {SP, P | H}, {SG, R | S}, {SG, Z}, {SG, Z},
           {SG, Z}, {SG, Z}, {SG, Z}, {SP, P | D | H}, {SI, R | S}, {SI, Z}};
    for (int i = 0; i < 18; i++) begin
      drive_cycle(bv[i]);
      vectors++;
      if (got !== ev[i]) begin
        errors++;
        $display("FAIL window_edges[%0d]: got %b want %b", i, got, ev[i]);
      end
    end
  endtask

  // Release sampled on the edge where the count sits at LONG_COUNT-1.
  task automatic test_threshold_race();
    logic       bv [15];
    logic [8:0] ev [15];
    for (int i = 0; i < 15; i++) bv[i] = (i < 8);
    ev = '{{SP, P | H}, {SP, H}, {SP, H}, {SP, H}, {SP, H}, {SP, H}, {SP, H},
           {SP, H}, {SG, R | S}, {SG, Z}, {SG, Z}, {SG, Z}, {SG, Z}, {SG, Z},
           {SI, Z}};
    for (int i = 0; i < 15; i++) begin
      drive_cycle(bv[i]);
      vectors++;
      if (got !== ev[i]) begin
        errors++;
        $display("FAIL threshold_race[%0d]: got %b want %b", i, got, ev[i]);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [8:0] ev [10];
    // Reach HOLD (long press on the 9th edge), then one more held cycle.
    for (int i = 0; i < 10; i++) drive_cycle(1'b1);
    vectors++;
    if (got !== {SH, H}) begin
      errors++;
      $display("FAIL pre_reset_hold: got %b want %b", got, {SH, H});
    end
    // Asynchronous assertion between edges must clear outputs immediately.
    reset = 1'b1;
    #1;
    vectors++;
    if (got !== {SI, Z}) begin
      errors++;
      $display("FAIL async_reset: got %b want %b", got, {SI, Z});
    end
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b1);
      vectors++;
      if (got !== {SI, Z}) begin
        errors++;
        $display("FAIL in_reset[%0d]: got %b want %b", i, got, {SI, Z});
      end
    end
    reset = 1'b0;
    ev = '{{SP, P | H}, {SP, H}, {SP, H}, {SP, H}, {SP, H}, {SP, H}, {SP, H},
           {SP, H}, {SH, L | H}, {SI, R}};
    for (int i = 0; i < 10; i++) begin
      drive_cycle(i < 9);
      vectors++;
      if (got !== ev[i]) begin
        errors++;
        $display("FAIL after_reset[%0d]: got %b want %b", i, got, ev[i]);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    vectors = 0;
    errors  = 0;
    reset   = 1'b1;
    btn_in  = 1'b0;

    test_reset();
    test_short_press();
    test_long_hold();
    test_double_click();
    test_window_edges();
    test_threshold_race();
    test_reset_mid_hold();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
